// File: rtl/rvskid_buf.sv
// Two-entry valid/ready elastic stage: a main register drives out_data, a skid register absorbs
// the one extra beat accepted while the consumer stalls. in_ready/out_valid come from flops.
module rvskid_buf #(
  parameter int unsigned WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Handshake flags are re-derived from the next state so they leave the block directly from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != StFull);
      out_valid_q <= (state_d != StEmpty);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (push) state_d = StOne;
        StOne: begin
          if (push && !pop)      state_d = StFull;
          else if (!push && pop) state_d = StEmpty;
        end
        StFull:  if (pop) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    in_ready  = in_ready_q;
    out_valid = out_valid_q;
    out_data  = main_q;
    count     = state_q;
  end

  // Flush clears the payload so discarded entries never show up on out_data.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = '0;
      skid_d = '0;
    end else begin
      unique case (state_q)
        StEmpty: if (push) main_d = in_data;
        StOne: begin
          if (push && pop)       main_d = in_data;
          else if (push && !pop) skid_d = in_data;
        end
        StFull:  if (pop) main_d = skid_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

endmodule

// File: tb/tb_rvskid_buf.sv
// Directed bench for rvskid_buf: reset, streaming, back-pressure, stability, push/pop and flush.
module tb_rvskid_buf;

  localparam int unsigned WIDTH = 14;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       count;

  int checks = 0;
  int errors = 0;

  rvskid_buf #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_val(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_count", {30'd0, count}, 32'd0);
    check("rst_out_data", {18'd0, out_data}, 32'd0);
    rst = 1'b0;

    // Reset asserted mid-FULL, checked before any clock edge
    push_val(14'h0ABC);
    push_val(14'h1234);
    check("fill_count", {30'd0, count}, 32'd2);
    check("fill_out_data", {18'd0, out_data}, 32'h0ABC);
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_count", {30'd0, count}, 32'd0);
    check("async_out_data", {18'd0, out_data}, 32'd0);
    step();
    rst = 1'b0;
    push_val(14'h0001);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);
    check("post_rst_data", {18'd0, out_data}, 32'h0001);
    out_ready = 1'b1;
    step();
    check("post_rst_drain", {30'd0, count}, 32'd0);

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 14'(i);
      step();
      check("stream_data", {18'd0, out_data}, 32'(i));
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      check("stream_count", {30'd0, count}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_empty", {30'd0, count}, 32'd0);

    // Back-pressure: third beat must wait for space
    out_ready = 1'b0;
    push_val(14'h1111);
    push_val(14'h2222);
    check("bp_count", {30'd0, count}, 32'd2);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head", {18'd0, out_data}, 32'h1111);
    in_valid = 1'b1;
    in_data  = 14'h3333;
    step();
    check("bp_blocked_count", {30'd0, count}, 32'd2);
    check("bp_blocked_head", {18'd0, out_data}, 32'h1111);
    out_ready = 1'b1;
    step();
    check("bp_pop1_data", {18'd0, out_data}, 32'h2222);
    check("bp_pop1_count", {30'd0, count}, 32'd1);
    check("bp_pop1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_pop2_data", {18'd0, out_data}, 32'h3333);
    check("bp_pop2_count", {30'd0, count}, 32'd1);
    in_valid = 1'b0;
    step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Stability while stalled in FULL
    out_ready = 1'b0;
    push_val(14'h0A01);
    push_val(14'h0A02);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 14'($urandom);
      step();
      check("stall_data", {18'd0, out_data}, 32'h0A01);
      check("stall_count", {30'd0, count}, 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("stall_drain1", {18'd0, out_data}, 32'h0A02);
    step();
    check("stall_drain2", {31'd0, out_valid}, 32'd0);

    // Simultaneous push and pop in ONE
    out_ready = 1'b0;
    push_val(14'h0AAA);
    check("pp_head", {18'd0, out_data}, 32'h0AAA);
    out_ready = 1'b1;
    push_val(14'h0BBB);
    check("pp_data", {18'd0, out_data}, 32'h0BBB);
    check("pp_count", {30'd0, count}, 32'd1);
    check("pp_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("pp_empty", {30'd0, count}, 32'd0);

    // Flush from FULL drops held entries and the concurrent push
    out_ready = 1'b0;
    push_val(14'h0123);
    push_val(14'h0456);
    check("fl_full", {30'd0, count}, 32'd2);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 14'h0789;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_count", {30'd0, count}, 32'd0);
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    check("fl_out_data", {18'd0, out_data}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("fl_stays_empty", {31'd0, out_valid}, 32'd0);
      check("fl_no_stale", {18'd0, out_data}, 32'd0);
    end
    push_val(14'h0055);
    check("fl_next_data", {18'd0, out_data}, 32'h0055);
    check("fl_next_valid", {31'd0, out_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
